fifo_rd_drain: RTL and testbench

Read-side consumer for the asynchronous FIFO. It sits entirely in the read clock domain. It issues `rd_en` against the FIFO read port (`rd_en`/`empty`/`data_out`), absorbs the one-cycle FIFO read latency in a 3-entry skid buffer, and presents words on a valid/ready stream. It also provides a flush mode that discards FIFO contents until empty, and counts delivered words.

---
 rtl/fifo_rd_drain.sv | 110 +++++++++++
 tb/tb_fifo_rd_drain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain for the async FIFO: rd_en -> data_out +1 cycle -> skid buffer -> m_valid +2 cycles.
// Reads stop once buffer plus in-flight reach 3, so m_ready never reaches rd_en; flush discards until empty.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            occ;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic                  capture;
  logic                  pop;
  logic                  done_nxt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = STREAM;
      end
      STREAM: begin
        // Reserve a slot for every outstanding read so a capture always fits.
        rd_en = !empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
        if (!en) state_nxt = IDLE;
      end
      FLUSH: begin
        rd_en = !empty;
        if (empty && !inflight) begin
          done_nxt  = 1'b1;
          state_nxt = en ? STREAM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = FLUSH;
      done_nxt  = 1'b0;
    end
  end

  assign capture = inflight && (state != FLUSH);
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign busy    = (state == FLUSH) || (occ != 2'd0) || inflight;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= IDLE;
      occ        <= 2'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      inflight   <= 1'b0;
      flush_done <= 1'b0;
      rd_count   <= '0;
      mem[0]     <= '0;
      mem[1]     <= '0;
      mem[2]     <= '0;
    end else begin
      state      <= state_nxt;
      inflight   <= rd_en;
      flush_done <= done_nxt;
      // A pop coinciding with flush still counts as delivered.
      if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
      if (flush) begin
        occ    <= 2'd0;
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
      end else begin
        if (capture) begin
          mem[wr_ptr] <= data_out;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({capture, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO modelled as a queue, delivered words scored in read order.
module tb_fifo_rd_drain;

  logic       clk = 1'b0;
  logic       rd_rst, en, flush, empty, m_ready;
  logic [7:0] data_out;
  logic       rd_en, m_valid, flush_done, busy;
  logic [7:0] m_data;
  logic [15:0] rd_count;
  logic       rd_en4, m_valid4, flush_done4, busy4;
  logic [7:0] m_data4;
  logic [3:0] rd_count4;

  always #5 clk = ~clk;

  fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .rd_clk(clk), .rd_rst(rd_rst), .en(en), .flush(flush), .empty(empty),
    .data_out(data_out), .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .flush_done(flush_done), .busy(busy), .rd_count(rd_count)
  );

  fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .rd_clk(clk), .rd_rst(rd_rst), .en(en), .flush(flush), .empty(empty),
    .data_out(data_out), .rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .flush_done(flush_done4), .busy(busy4), .rd_count(rd_count4)
  );

  int tests = 0;
  int fails = 0;
  int q[$];
  int exp_q[$];
  int cnt = 0;
  bit flushing = 0, infl = 0, infl_kept = 0, exp_fd = 0, force_e = 0, hold_v = 0;
  logic [7:0] hold_d;
  bit last_rd, last_pop, last_fd, last_mv, last_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: check at negedge, then model the FIFO read port after the edge.
  task automatic tick();
    int w;
    bit rd_now;
    empty = force_e || (q.size() == 0);
    @(negedge clk);
    chk("rd_en_while_empty", {31'b0, rd_en & empty}, 0);
    chk("rd_en4_while_empty", {31'b0, rd_en4 & empty}, 0);
    chk("flush_done", {31'b0, flush_done}, {31'b0, exp_fd});
    chk("flush_done4", {31'b0, flush_done4}, {31'b0, exp_fd});
    chk("rd_count", {16'b0, rd_count}, cnt & 16'hffff);
    chk("rd_count4", {28'b0, rd_count4}, cnt & 15);
    chk("m_valid", {31'b0, m_valid}, (exp_q.size() > int'(infl_kept)) ? 1 : 0);
    chk("m_valid4", {31'b0, m_valid4}, (exp_q.size() > int'(infl_kept)) ? 1 : 0);
    if (hold_v) chk("m_data_hold", {24'b0, m_data}, {24'b0, hold_d});
    last_pop  = m_valid && m_ready;
    last_mv   = m_valid;
    last_busy = busy;
    last_fd   = flush_done;
    if (last_pop) begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("m_data", {24'b0, m_data}, w);
        chk("m_data4", {24'b0, m_data4}, w);
      end
      cnt++;
    end
    hold_v = m_valid && !m_ready && !flush;
    hold_d = m_data;
    exp_fd = flushing && !flush && empty && !infl;
    if (exp_fd) flushing = 0;
    if (flush) begin
      flushing = 1;
      exp_q.delete();
    end
    rd_now  = rd_en;
    last_rd = rd_now;
    @(posedge clk);
    #1;
    if (rd_now && q.size() > 0) begin
      w = q.pop_front();
      data_out = w[7:0];
      if (!flushing) exp_q.push_back(w);
    end
    infl      = rd_now;
    infl_kept = rd_now && !flushing;
    flush     = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    en = 1'b1; m_ready = 1'b1; force_e = 0; flush = 1'b0;
    while (!(q.size() == 0 && exp_q.size() == 0 && !infl) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, q.size() + exp_q.size(), 0);
  endtask

  initial begin
    bit rdv[10];
    bit pv[10];
    int rdc, fdc, base;
    rd_rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0; data_out = 8'h00; empty = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", {31'b0, rd_en}, 0);
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_m_data", {24'b0, m_data}, 0);
    chk("rst_flush_done", {31'b0, flush_done}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rd_count", {16'b0, rd_count}, 0);
    chk("rst_rd_count4", {28'b0, rd_count4}, 0);

    // Reset held with data available and en high, then streaming of 4 words.
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    en = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    tick();
    chk("rst_held_rd_en", {31'b0, last_rd}, 0);
    rd_rst = 1'b0;
    tick();
    chk("rst_release_rd_en", {31'b0, last_rd}, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      rdv[i] = last_rd;
      pv[i]  = last_pop;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stream_rd_en[%0d]", i), {31'b0, rdv[i]}, (i < 4) ? 1 : 0);
      chk($sformatf("stream_pop[%0d]", i), {31'b0, pv[i]}, (i >= 2 && i < 6) ? 1 : 0);
    end
    chk("stream_count", {16'b0, rd_count}, 4);

    // Backpressure: only three reads until the sink accepts.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) q.push_back(8'hA0 + i);
    rdc = 0;
    repeat (12) begin
      tick();
      rdc += int'(last_rd);
    end
    chk("bp_rd_pulses", rdc, 3);
    chk("bp_m_valid", {31'b0, m_valid}, 1);
    chk("bp_m_data", {24'b0, m_data}, 8'hA0);
    drain("bp_drained");
    chk("bp_count", {16'b0, rd_count}, 4 + 10);

    // Empty flag toggling every cycle mid-stream.
    for (int i = 0; i < 8; i++) q.push_back(8'hB0 + i);
    for (int i = 0; i < 30; i++) begin
      force_e = (i % 2) == 0;
      tick();
    end
    drain("toggle_drained");
    chk("toggle_count", {16'b0, rd_count}, 14 + 8);

    // Flush with 2 words buffered and 5 waiting in the FIFO.
    m_ready = 1'b0;
    q.push_back(8'hC0); q.push_back(8'hC1);
    repeat (4) tick();
    chk("pre_flush_m_valid", {31'b0, m_valid}, 1);
    force_e = 1;
    for (int i = 2; i < 7; i++) q.push_back(8'hC0 + i);
    tick();
    force_e = 0;
    flush = 1'b1;
    base = cnt;
    rdc = 0;
    fdc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rdc += int'(last_rd);
      fdc += int'(last_fd);
      if (i == 1) chk("flush_m_valid_drop", {31'b0, last_mv}, 0);
      if (i == 2) chk("flush_busy", {31'b0, last_busy}, 1);
    end
    chk("flush_rd_pulses", rdc, 5);
    chk("flush_done_pulses", fdc, 1);
    chk("flush_count", {16'b0, rd_count}, base);
    q.push_back(8'hD0);
    drain("post_flush_drained");
    chk("post_flush_count", {16'b0, rd_count}, base + 1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      en      = $urandom_range(0, 7) != 0;
      m_ready = $urandom_range(0, 3) != 0;
      force_e = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 2) == 0 && q.size() < 20) q.push_back(int'($urandom_range(0, 255)));
      flush = $urandom_range(0, 49) == 0;
      tick();
    end
    drain("rand_drained");

    en = 1'b0;
    repeat (3) tick();
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_busy4", {31'b0, busy4}, 0);
    chk("wrap_count4", {28'b0, rd_count4}, cnt % 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
